// File: rtl/baud_gen.sv
// Baud-rate generator: programmable oversample tick, mid-bit and bit-period ticks,
// and a bit-rate square wave. A new divisor takes effect only at a period boundary.
module baud_gen #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_DIV = 650
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 load,
    input  logic                 restart,
    output logic                 tick_os,
    output logic                 tick_bit,
    output logic                 tick_mid,
    output logic                 clk_out,
    output logic [DIV_WIDTH-1:0] div_active
);

    localparam int unsigned    BW          = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [BW-1:0]  BIT_LAST    = BW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0]  BIT_MID_PRE = BW'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] r_os_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DIV_WIDTH-1:0] r_div_active;
    logic [DIV_WIDTH-1:0] r_pend_val;
    logic                 r_pend;
    logic                 r_tick_os;
    logic                 r_tick_bit;
    logic                 r_tick_mid;
    logic                 r_clk_out;

    logic                 w_wrap;
    logic                 w_commit;
    logic                 w_bit_last;
    logic [BW-1:0]        w_bit_next;

    // restart wins over a coincident wrap; every non-counting edge is a safe commit point
    assign w_wrap     = en & ~restart & (r_os_cnt == r_div_active);
    assign w_commit   = restart | ~en | w_wrap;
    assign w_bit_last = (r_bit_cnt == BIT_LAST);
    assign w_bit_next = w_bit_last ? '0 : r_bit_cnt + BW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_div_active <= DIV_WIDTH'(DEFAULT_DIV);
            r_pend_val   <= '0;
            r_pend       <= 1'b0;
            r_tick_os    <= 1'b0;
            r_tick_bit   <= 1'b0;
            r_tick_mid   <= 1'b0;
            r_clk_out    <= 1'b0;
        end else begin
            r_tick_os  <= w_wrap;
            r_tick_bit <= w_wrap & w_bit_last;
            r_tick_mid <= w_wrap & (r_bit_cnt == BIT_MID_PRE);

            if (restart) begin
                r_os_cnt  <= '0;
                r_bit_cnt <= '0;
            end else if (en) begin
                if (w_wrap) begin
                    r_os_cnt  <= '0;
                    r_bit_cnt <= w_bit_next;
                    if (w_bit_last) begin
                        r_clk_out <= ~r_clk_out;
                    end
                end else begin
                    r_os_cnt <= r_os_cnt + DIV_WIDTH'(1);
                end
            end

            // a strobe on a commit edge bypasses the pending register
            if (w_commit) begin
                if (load) begin
                    r_div_active <= divisor;
                end else if (r_pend) begin
                    r_div_active <= r_pend_val;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend_val <= divisor;
                r_pend     <= 1'b1;
            end
        end
    end

    assign tick_os    = r_tick_os;
    assign tick_bit   = r_tick_bit;
    assign tick_mid   = r_tick_mid;
    assign clk_out    = r_clk_out;
    assign div_active = r_div_active;

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen at OVERSAMPLE=4; each task checks its own scenario inline.
`timescale 1ns/1ps
module tb_baud_gen;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] divisor;
    logic          load;
    logic          restart;
    logic          tick_os;
    logic          tick_bit;
    logic          tick_mid;
    logic          clk_out;
    logic [DW-1:0] div_active;

    int checks;
    int failures;

    baud_gen #(
        .DIV_WIDTH  (DW),
        .OVERSAMPLE (4),
        .DEFAULT_DIV(650)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .divisor   (divisor),
        .load      (load),
        .restart   (restart),
        .tick_os   (tick_os),
        .tick_bit  (tick_bit),
        .tick_mid  (tick_mid),
        .clk_out   (clk_out),
        .div_active(div_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; restart = 1'b0; divisor = '0;
        #1;
        checks++;
        if ({tick_os, tick_bit, tick_mid, clk_out} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outs got=%b exp=0000", {tick_os, tick_bit, tick_mid, clk_out});
        end
        step(); step();
        checks++;
        if (div_active !== 16'd650) begin
            failures++;
            $display("FAIL reset_div got=%0d exp=650", div_active);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_rates();
        logic [3:0] exp_v;
        load = 1'b1; divisor = 16'd3;
        step();
        load = 1'b0;
        checks++;
        if (div_active !== 16'd3) begin
            failures++;
            $display("FAIL basic_load got=%0d exp=3", div_active);
        end
        en = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            step();
            exp_v = {(c % 4 == 0), (c % 16 == 0), (c % 16 == 8), ((c / 16) % 2 == 1)};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL basic c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
    endtask

    task automatic test_div_change();
        logic [3:0] exp_v;
        step();
        load = 1'b1; divisor = 16'd5;
        step();
        load = 1'b0;
        checks++;
        if (div_active !== 16'd3) begin
            failures++;
            $display("FAIL divchg_hold got=%0d exp=3", div_active);
        end
        step(); step();
        checks++;
        if ({tick_os, div_active} !== {1'b1, 16'd5}) begin
            failures++;
            $display("FAIL divchg_wrap got=%b/%0d exp=1/5", tick_os, div_active);
        end
        for (int c = 1; c <= 18; c++) begin
            step();
            exp_v = {(c % 6 == 0), (c == 18), (c == 6), (c == 18)};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL divchg c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
    endtask

    task automatic test_restart();
        logic [3:0] exp_v;
        en = 1'b0; load = 1'b1; divisor = 16'd3;
        step();
        load = 1'b0;
        checks++;
        if (div_active !== 16'd3) begin
            failures++;
            $display("FAIL rst_load got=%0d exp=3", div_active);
        end
        en = 1'b1;
        for (int c = 1; c <= 9; c++) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({tick_os, tick_bit, tick_mid, clk_out} !== 4'b0001) begin
            failures++;
            $display("FAIL restart_edge got=%b exp=0001", {tick_os, tick_bit, tick_mid, clk_out});
        end
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_v = {(c % 4 == 0), 1'b0, (c == 8), 1'b1};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL restart c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({tick_os, tick_bit, tick_mid, clk_out} !== 4'b0001) begin
            failures++;
            $display("FAIL restart_on_wrap got=%b exp=0001", {tick_os, tick_bit, tick_mid, clk_out});
        end
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_v = {(c == 4), 1'b0, 1'b0, 1'b1};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL restart2 c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
    endtask

    task automatic test_load_commit();
        logic [3:0] exp_v;
        load = 1'b1; divisor = 16'd9;
        step();
        divisor = 16'd2;
        step();
        load = 1'b0;
        checks++;
        if (div_active !== 16'd3) begin
            failures++;
            $display("FAIL pend_hold got=%0d exp=3", div_active);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if (div_active !== 16'd2) begin
            failures++;
            $display("FAIL pend_overwrite got=%0d exp=2", div_active);
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            exp_v = {(c == 3), 1'b0, 1'b0, 1'b1};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL div2 c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
        load = 1'b1; divisor = 16'd7;
        step();
        divisor = 16'd1; restart = 1'b1;
        step();
        load = 1'b0; restart = 1'b0;
        checks++;
        if (div_active !== 16'd1) begin
            failures++;
            $display("FAIL load_on_commit got=%0d exp=1", div_active);
        end
    endtask

    task automatic test_edge_cases();
        logic [3:0] exp_v;
        en = 1'b0; load = 1'b1; divisor = 16'd0; restart = 1'b1;
        step();
        load = 1'b0; restart = 1'b0;
        checks++;
        if (div_active !== 16'd0) begin
            failures++;
            $display("FAIL div0_load got=%0d exp=0", div_active);
        end
        en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_v = {1'b1, (c % 4 == 0), (c % 4 == 2), (c < 4 || c == 8)};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL div0 c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
        en = 1'b0; load = 1'b1; divisor = 16'd3; restart = 1'b1;
        step();
        load = 1'b0; restart = 1'b0; en = 1'b1;
        step(); step();
        en = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            step();
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== 4'b0001) begin
                failures++;
                $display("FAIL freeze c=%0d got=%b exp=0001", c, {tick_os, tick_bit, tick_mid, clk_out});
            end
        end
        en = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            step();
            exp_v = {(c == 2), 1'b0, 1'b0, 1'b1};
            checks++;
            if ({tick_os, tick_bit, tick_mid, clk_out} !== exp_v) begin
                failures++;
                $display("FAIL resume c=%0d got=%b exp=%b", c, {tick_os, tick_bit, tick_mid, clk_out}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; divisor = 16'd5;
        step();
        load = 1'b0;
        checks++;
        if ({clk_out, div_active} !== {1'b1, 16'd3}) begin
            failures++;
            $display("FAIL pre_reset got=%b/%0d exp=1/3", clk_out, div_active);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick_os, tick_bit, tick_mid, clk_out, div_active} !== {4'b0000, 16'd650}) begin
            failures++;
            $display("FAIL async_reset got=%b/%0d exp=0000/650", {tick_os, tick_bit, tick_mid, clk_out}, div_active);
        end
        step(); step();
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) step();
        en = 1'b0;
        step();
        checks++;
        if (div_active !== 16'd650) begin
            failures++;
            $display("FAIL pend_discard got=%0d exp=650", div_active);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_rates();
        test_div_change();
        test_restart();
        test_load_commit();
        test_edge_cases();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
